// File: rtl/pll_reset_seq.sv
// pll_reset_seq: qualifies the PLL lock, sequences the game-core reset
// and derives the pixel/CPU clock-enables from the single PLL clock.
module pll_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_HOLD    = 256,
  parameter int PIX_DIV     = 4,
  parameter int CPU_DIV     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic       ce_pix,
  output logic       ce_cpu,
  output logic [1:0] state
);

  localparam int CMAX =
    (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int UW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  localparam logic [CW-1:0] STABLE_END = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_END   = CW'(RST_HOLD - 1);
  localparam logic [PW-1:0] PIX_END    = PW'(PIX_DIV - 1);
  localparam logic [UW-1:0] CPU_END    = UW'(CPU_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  state_t                 cur;
  state_t                 nxt;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic [PW-1:0]          pix_cnt;
  logic [PW-1:0]          pix_nxt;
  logic [UW-1:0]          cpu_cnt;
  logic [UW-1:0]          cpu_nxt;
  logic                   run_nxt;
  logic                   run_cont;

  assign lock_s = sync[SYNC_STAGES-1];
  assign state  = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    if (!lock_s) begin
      nxt     = WAIT_LOCK;
      cnt_nxt = '0;
    end else if (soft_rst && (cur == HOLD || cur == RUN)) begin
      nxt     = HOLD;
      cnt_nxt = '0;
    end else begin
      unique case (cur)
        WAIT_LOCK: begin
          nxt     = STABLE;
          cnt_nxt = '0;
        end
        STABLE: begin
          if (cnt == STABLE_END) begin
            nxt     = HOLD;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HOLD: begin
          if (cnt == HOLD_END) begin
            nxt     = RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RUN: begin
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Dividers only advance across consecutive RUN cycles, so every
  // RUN entry starts them phase-aligned from zero.
  assign run_nxt  = (nxt == RUN);
  assign run_cont = run_nxt && (cur == RUN);

  always_comb begin
    pix_nxt = '0;
    cpu_nxt = '0;
    if (run_cont) begin
      pix_nxt = (pix_cnt == PIX_END) ? '0 : pix_cnt + PW'(1);
      cpu_nxt = (cpu_cnt == CPU_END) ? '0 : cpu_cnt + UW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= WAIT_LOCK;
      cnt        <= '0;
      pix_cnt    <= '0;
      cpu_cnt    <= '0;
      core_rst_n <= 1'b0;
      ready      <= 1'b0;
      ce_pix     <= 1'b0;
      ce_cpu     <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      pix_cnt    <= pix_nxt;
      cpu_cnt    <= cpu_nxt;
      core_rst_n <= run_nxt;
      ready      <= run_nxt;
      ce_pix     <= run_nxt && (pix_nxt == PIX_END);
      ce_cpu     <= run_nxt && (cpu_nxt == CPU_END);
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed scenarios plus random lock/soft/reset
// traffic, checked every cycle against a timing-rule reference model.
module tb_pll_reset_seq;

  localparam int SS = 2;
  localparam int LS = 8;
  localparam int RH = 4;
  localparam int PD = 4;
  localparam int CD = 10;
  localparam int SAT = 100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock = 1'b0;
  logic       soft_rst = 1'b0;
  logic       core_rst_n;
  logic       ready;
  logic       ce_pix;
  logic       ce_cpu;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int seq[$];

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES(SS),
    .LOCK_STABLE(LS),
    .RST_HOLD   (RH),
    .PIX_DIV    (PD),
    .CPU_DIV    (CD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .soft_rst  (soft_rst),
    .core_rst_n(core_rst_n),
    .ready     (ready),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .state     (state)
  );

  // Reference model: phase is derived from how many edges the
  // synchronised lock has been seen high and how long ago a soft
  // reset was honoured; enables from the length of the RUN stretch.
  bit hist[SS];
  int lrun;
  int sage;
  int rcyc;
  int mst;

  function automatic int phase_of(int l, int s);
    if (l == 0) return 0;
    if (l <= LS) return 1;
    if (s < RH || l <= LS + RH) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    lrun = 0;
    sage = SAT;
    rcyc = 0;
    mst  = 0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    bit seen;
    bit soft_ok;
    if (rst_n) begin
      seen    = hist[SS-1];
      soft_ok = seen && soft_rst && (mst >= 2);
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pll_lock;
      lrun = seen ? ((lrun < SAT) ? lrun + 1 : lrun) : 0;
      if (!seen) sage = SAT;
      else if (soft_ok) sage = 0;
      else if (sage < SAT) sage++;
      mst  = phase_of(lrun, sage);
      rcyc = (mst == 3) ? rcyc + 1 : 0;
    end
  end

  always @(negedge clk) begin
    logic er;
    logic ep;
    logic ec;
    er = (mst == 3);
    ep = er && (rcyc % PD == 0);
    ec = er && (rcyc % CD == 0);
    tests++;
    if (core_rst_n !== er || ready !== er || ce_pix !== ep ||
        ce_cpu !== ec || state !== 2'(mst)) begin
      fails++;
      $display("FAIL cycle t=%0t state %0d want %0d rstn %b want %b rdy %b want %b pix %b want %b cpu %b want %b",
               $time, state, mst, core_rst_n, er, ready, er,
               ce_pix, ep, ce_cpu, ec);
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Edges until core_rst_n reaches lvl; records the state trail.
  task automatic edges_core(input string nm, input logic lvl,
                            input int exp);
    int n;
    n = 0;
    seq.delete();
    seq.push_back(int'(state));
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (int'(state) != seq[seq.size()-1]) seq.push_back(int'(state));
      if (core_rst_n === lvl) begin
        n = i;
        break;
      end
    end
    check(nm, n, exp);
  endtask

  task automatic run_probe(input int ncyc, output int fp, output int fc,
                           output int np, output int nc);
    fp = 0; fc = 0; np = 0; nc = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (ce_pix) begin
        np++;
        if (fp == 0) fp = k;
      end
      if (ce_cpu) begin
        nc++;
        if (fc == 0) fc = k;
      end
      if (k < ncyc) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int fp, fc, np, nc, n;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_ce_pix", ce_pix, 0);
    check("rst_ce_cpu", ce_cpu, 0);
    check("rst_state", state, 0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Lock rise to RUN
    pll_lock = 1'b1;
    edges_core("lock_to_run", 1'b1, 15);
    check("state_trail_len", seq.size(), 4);
    for (int i = 0; i < seq.size() && i < 4; i++)
      check("state_trail", seq[i], i);

    // Dividers in RUN
    run_probe(40, fp, fc, np, nc);
    check("first_pix", fp, PD);
    check("first_cpu", fc, CD);
    check("pix_pulses_40", np, 40 / PD);
    check("cpu_pulses_40", nc, 40 / CD);

    // Lock loss in RUN for 3 cycles
    @(negedge clk);
    pll_lock = 1'b0;
    edges_core("lockloss_drop", 1'b0, SS + 1);
    @(negedge clk);
    pll_lock = 1'b1;
    edges_core("lockloss_rerun", 1'b1, 15);

    // Lock loss in STABLE at cnt=5
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    pll_lock = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("stable_mid_state", state, 1);
    @(negedge clk);
    pll_lock = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (state == 2'd0) begin
        n = i;
        break;
      end
    end
    check("stable_drop_edges", n, 3);
    @(negedge clk);
    pll_lock = 1'b1;
    edges_core("stable_rerun", 1'b1, 15);

    // Soft reset pulse in RUN
    repeat (7) @(negedge clk);
    soft_rst = 1'b1;
    @(posedge clk);
    #1 soft_rst = 1'b0;
    n = (core_rst_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 20 && !core_rst_n; i++) begin
      @(posedge clk);
      #1;
      if (!core_rst_n) n++;
    end
    check("soft_low_cycles", n, RH);
    run_probe(12, fp, fc, np, nc);
    check("soft_first_pix", fp, PD);
    check("soft_first_cpu", fc, CD);

    // Second soft pulse during HOLD extends it
    @(negedge clk);
    soft_rst = 1'b1;
    @(posedge clk);
    #1 soft_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    soft_rst = 1'b1;
    @(posedge clk);
    #1 soft_rst = 1'b0;
    n = 3;
    for (int i = 0; i < 20 && !core_rst_n; i++) begin
      @(posedge clk);
      #1;
      if (!core_rst_n) n++;
    end
    check("soft_twice_low", n, 2 + RH);

    // Async reset mid-HOLD
    repeat (5) @(negedge clk);
    soft_rst = 1'b1;
    @(posedge clk);
    #1 soft_rst = 1'b0;
    check("hold_state", state, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_core_rst_n", core_rst_n, 0);
    check("arst_ready", ready, 0);
    check("arst_ce_pix", ce_pix, 0);
    check("arst_ce_cpu", ce_cpu, 0);
    check("arst_state", state, 0);
    #1 rst_n = 1'b1;
    edges_core("arst_rerun", 1'b1, 15);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      int act;
      act = $urandom_range(0, 9);
      @(negedge clk);
      if (act == 5) begin
        pll_lock = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        pll_lock = 1'b1;
      end else if (act == 6) begin
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
      end else if (act == 7) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
